// File: rtl/spike_window_classifier.sv
// Spike-count readout: integrates per-class spikes over a fixed window, then
// scans the counts sequentially to pick the winning class (lowest index on ties).

module swc_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] cnt
);
  // Saturating counter: stops at all-ones rather than wrapping.
  always_ff @(posedge clk)
    if (!rst_n || clr)                  cnt <= '0;
    else if (en && spike && cnt != '1)  cnt <= cnt + CNT_W'(1);
endmodule

module spike_window_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLASSES-1:0] spike_i,
  input  logic                   start_i,
  input  logic                   result_ready_i,
  output logic                   busy_o,
  output logic                   result_valid_o,
  output logic [3:0]             class_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   tie_o
);
  localparam int               IDX_W    = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, HOLD} state_t;
  state_t state, state_nxt;

  logic [NUM_CLASSES-1:0][CNT_W-1:0] cnt;
  logic [15:0]      win_cnt;
  logic [IDX_W-1:0] idx, best_idx, best_idx_nxt;
  logic [CNT_W-1:0] scan_cnt, best_cnt, best_cnt_nxt;
  logic             best_tie, best_tie_nxt;
  logic             clr, acc_en, scan_last;

  assign clr       = (state == IDLE) && start_i;
  assign acc_en    = (state == ACCUM);
  assign scan_last = (state == SCAN) && (idx == IDX_LAST);

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
    swc_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (acc_en),
      .spike (spike_i[k]),
      .cnt   (cnt[k])
    );
  end

  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i)             state_nxt = ACCUM;
      ACCUM:   if (win_cnt == WIN_LAST) state_nxt = SCAN;
      SCAN:    if (idx == IDX_LAST)     state_nxt = HOLD;
      HOLD:    if (result_ready_i)      state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Index 0 seeds the running best; later equal counts only flag a tie.
  assign scan_cnt = cnt[idx];
  always_comb begin
    best_cnt_nxt = best_cnt;
    best_idx_nxt = best_idx;
    best_tie_nxt = best_tie;
    if (idx == '0 || scan_cnt > best_cnt) begin
      best_cnt_nxt = scan_cnt;
      best_idx_nxt = idx;
      best_tie_nxt = 1'b0;
    end else if (scan_cnt == best_cnt) begin
      best_tie_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (!rst_n) begin
      win_cnt  <= '0;
      idx      <= '0;
      best_cnt <= '0;
      best_idx <= '0;
      best_tie <= 1'b0;
      class_o  <= '0;
      count_o  <= '0;
      tie_o    <= 1'b0;
    end else begin
      if (clr)         win_cnt <= '0;
      else if (acc_en) win_cnt <= win_cnt + 16'd1;
      if (state == SCAN) begin
        idx      <= idx + IDX_W'(1);
        best_cnt <= best_cnt_nxt;
        best_idx <= best_idx_nxt;
        best_tie <= best_tie_nxt;
        // Result registers change only on the edge that enters HOLD.
        if (scan_last) begin
          class_o <= 4'(best_idx_nxt);
          count_o <= best_cnt_nxt;
          tie_o   <= best_tie_nxt;
        end
      end else begin
        idx <= '0;
      end
    end

  assign busy_o         = (state != IDLE);
  assign result_valid_o = (state == HOLD);
endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed bench for spike_window_classifier: expected results are queued at
// launch and checked when result_valid_o rises; a second instance covers saturation.

module tb_spike_window_classifier;
  logic       clk = 1'b0;
  logic       rst_n, start, start_s, ready;
  logic [9:0] spike;

  logic       busy, valid, tie;
  logic [3:0] class_o;
  logic [7:0] count;
  logic       s_busy, s_valid, s_tie;
  logic [3:0] s_class;
  logic [3:0] s_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int e_cyc = 0;
  logic [12:0] exp_q[$];
  logic [12:0] cur_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spike_window_classifier #(.NUM_CLASSES(10), .CNT_W(8), .WINDOW(16)) dut (
    .clk(clk), .rst_n(rst_n), .spike_i(spike), .start_i(start),
    .result_ready_i(ready), .busy_o(busy), .result_valid_o(valid),
    .class_o(class_o), .count_o(count), .tie_o(tie)
  );

  spike_window_classifier #(.NUM_CLASSES(10), .CNT_W(4), .WINDOW(32)) dut_s (
    .clk(clk), .rst_n(rst_n), .spike_i(spike), .start_i(start_s),
    .result_ready_i(ready), .busy_o(s_busy), .result_valid_o(s_valid),
    .class_o(s_class), .count_o(s_count), .tie_o(s_tie)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] pat(input int tst, input int i);
    logic [9:0] p;
    p = '0;
    case (tst)
      1: p[3] = 1'b1;
      2: begin p[2] = 1'b1; p[7] = 1'b1; p[5] = (i < 8); end
      4: begin p[1] = (i % 2 == 0); p[2] = (i % 2 == 0); p[4] = 1'b1; end
      6: p[9] = 1'b1;
      7: begin p[5] = 1'b1; p[2] = (i < 10); end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic launch(input int tst, input int len, input bit sel, input logic [12:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    if (sel) start_s = 1'b1; else start = 1'b1;
    spike = '0;
    @(negedge clk);
    start = 1'b0; start_s = 1'b0; e_cyc = cyc;
    chk("busy_accum", sel ? s_busy : busy, 1'b1);
    for (int i = 0; i < len; i++) begin
      spike = pat(tst, i);
      @(negedge clk);
    end
    // Silence test keeps spiking through SCAN/HOLD; those spikes must not count.
    spike = (tst == 3) ? '1 : '0;
  endtask

  task automatic collect(input bit sel, input int lat);
    int n;
    logic [12:0] got;
    n = 0;
    while (!(sel ? s_valid : valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_rise", sel ? s_valid : valid, 1'b1);
    chk("latency", cyc - e_cyc, lat);
    got = sel ? {s_class, 4'b0, s_count, s_tie} : {class_o, count, tie};
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
      cur_exp = '0;
    end else begin
      cur_exp = exp_q.pop_front();
      chk("class", got[12:9], cur_exp[12:9]);
      chk("count", got[8:1], cur_exp[8:1]);
      chk("tie", got[0], cur_exp[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; ready = 1'b1; spike = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_class", class_o, 0);
    chk("rst_count", count, 0);
    chk("rst_tie", tie, 0);
    rst_n = 1'b1;

    // Single winner, then one-cycle valid and result held in IDLE.
    launch(1, 16, 0, {4'd3, 8'd16, 1'b0});
    collect(0, 26);
    @(negedge clk);
    chk("valid_one_cycle", valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold_class", class_o, 3);
    chk("idle_hold_count", count, 16);

    // Tie between classes 2 and 7: lower index wins.
    launch(2, 16, 0, {4'd2, 8'd16, 1'b1});
    collect(0, 26);

    // Silence with spikes during SCAN/HOLD.
    launch(3, 16, 0, {4'd0, 8'd0, 1'b1});
    collect(0, 26);
    spike = '0;
    @(negedge clk);

    // Backpressure: hold 5 cycles with start pulses, then handshake with start high.
    ready = 1'b0;
    launch(4, 16, 0, {4'd4, 8'd16, 1'b0});
    collect(0, 26);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      @(negedge clk);
      chk("bp_valid", valid, 1);
      chk("bp_stable", {class_o, count, tie}, cur_exp);
    end
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("handshake_busy", busy, 0);
    chk("handshake_valid", valid, 0);
    start = 1'b0;
    @(negedge clk);
    chk("start_on_handshake_ignored", busy, 0);

    // Abort mid-ACCUM with reset, then a clean window.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; spike = '1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_result", {class_o, count, tie}, 0);
    rst_n = 1'b1; spike = '0;
    launch(6, 16, 0, {4'd9, 8'd16, 1'b0});
    collect(0, 26);
    @(negedge clk);

    // Saturation on the narrow-counter instance.
    launch(7, 32, 1, {4'd5, 8'd15, 1'b0});
    collect(1, 42);
    @(negedge clk);
    chk("sat_busy_after", s_busy, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spike_window_classifier.md
SPIKE_WINDOW_CLASSIFIER -- requirements
Module: spike_window_classifier

Interface
REQ-001 The block SHALL have parameter NUM_CLASSES, default 10, the number of readout spike lanes (2..16).
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of each per-class spike counter.
REQ-003 The block SHALL have parameter WINDOW, default 64, the number of cycles in one integration window (2..65535).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 spike_i  input  NUM_CLASSES  per-class spike from the hidden/readout layer, sampled once per cycle.
REQ-007 start_i  input  1  request to begin one window; honoured only in IDLE.
REQ-008 result_ready_i  input  1  downstream accepts the result.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 result_valid_o  output  1  result fields are valid; high only in HOLD.
REQ-011 class_o  output  4  index of the winning class.
REQ-012 count_o  output  CNT_W  spike count of the winning class.
REQ-013 tie_o  output  1  at least one other class has a count equal to count_o.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ACCUM, SCAN and HOLD.
REQ-015 IDLE with start_i=1 -> ACCUM; on the same edge, all class counters and the window counter clear to 0.
REQ-016 In ACCUM, each cycle, counter[k] SHALL increment by spike_i[k] and saturate at 2^CNT_W-1 (no wrap).
REQ-017 ACCUM SHALL last exactly WINDOW cycles; on the cycle the window counter equals WINDOW-1, it samples spikes and moves to SCAN.
REQ-018 SCAN SHALL visit one class per cycle, from index 0 to NUM_CLASSES-1, lasting exactly NUM_CLASSES cycles, then move to HOLD.
REQ-019 Index 0 SHALL seed best=count[0] and clear tie.
REQ-020 Each later index k with count[k] > best SHALL replace best and index, and clear tie.
REQ-021 Each later index k with count[k] == best SHALL set tie and keep the lower index.
REQ-022 Consequence of REQ-019..021: on equal counts the lowest index wins.
REQ-023 spike_i SHALL be ignored outside ACCUM.
REQ-024 In HOLD, result_valid_o=1, and class_o, count_o and tie_o SHALL remain stable until result_valid_o && result_ready_i; on that edge the FSM moves to IDLE.
REQ-025 If result_ready_i is already high on entry to HOLD, result_valid_o SHALL be high for exactly one cycle.
REQ-026 Latency: with start_i accepted at edge E, result_valid_o SHALL rise at edge E+WINDOW+NUM_CLASSES.
REQ-027 start_i SHALL be ignored (no restart, no queueing) in ACCUM, SCAN and HOLD, including on the HOLD->IDLE handshake edge.
REQ-028 All-zero counts SHALL give class_o=0, count_o=0, and tie_o=1.
REQ-029 class_o, count_o and tie_o SHALL hold their last result while in IDLE and SHALL update only when entering HOLD.

Reset
REQ-030 While rst_n=0 at a clock edge: FSM=IDLE; all counters 0; busy_o=0; result_valid_o=0; class_o=0; count_o=0; tie_o=0.
REQ-031 Reset SHALL take priority over every other input in every state; a window in progress SHALL be discarded without producing a result.

Verification (NUM_CLASSES=10, CNT_W=8, WINDOW=16 unless stated)
REQ-032 Single winner: spike_i[3]=1 throughout, others 0 -> class_o=3, count_o=16, tie_o=0, valid at E+26.
REQ-033 Tie: spike_i[2] and spike_i[7] high throughout; spike_i[5] high for 8 cycles -> class_o=2, count_o=16, tie_o=1.
REQ-034 Silence and ignore rule: no spikes -> class_o=0, count_o=0, tie_o=1; spikes applied during SCAN and HOLD do not change counts.
REQ-035 Saturation: CNT_W=4, WINDOW=32, spike_i[5]=1 throughout -> class_o=5, count_o=15, tie_o=0.
REQ-036 Backpressure: result_ready_i low for 5 HOLD cycles -> outputs stable and start_i pulses ignored; ready high -> IDLE the next cycle, busy_o=0.
REQ-037 Reset mid-ACCUM at cycle 8 -> IDLE with all outputs 0; a new start with spike_i[9]=1 -> class_o=9, count_o=16, with no residue from the aborted window.
